// File: rtl/group_spike_encoder.sv
// Group spike encoder: folds PDE-phase spike events into per-group codes and double-buffers them
// for the consumer. Optional macro SPIKE_CNT_EN adds registered popcounts of the published maps.
module group_spike_encoder #(
    parameter int N_NUM = 32,
    parameter int G_NUM = 4,
    parameter int N_SZ  = 5,
    parameter int G_SZ  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       state,
    input  logic             spike_valid,
    input  logic             spike_src,
    input  logic [N_SZ-1:0]  spike_idx,
    input  logic             gs_ready,
    output logic [G_NUM-1:0] GS_code_0,
    output logic [G_NUM-1:0] GS_code_1,
    output logic [N_NUM-1:0] spike_map_0,
    output logic [N_NUM-1:0] spike_map_1,
    output logic             shift_en,
    output logic             busy,
    output logic [7:0]       drop_cnt,
    output logic [N_SZ:0]    spike_cnt_0,
    output logic [N_SZ:0]    spike_cnt_1,
    output logic [1:0]       dbg_state
);

    localparam logic [2:0] PDE   = 3'b100;
    localparam int         GRP_W = N_NUM >> G_SZ;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUBLISH = 2'd2
    } fsm_t;

    fsm_t             state_q, state_d;
    logic [N_NUM-1:0] pend_0, pend_1;
    logic [G_NUM-1:0] code_d0, code_d1;
    logic             consumed;
    logic             in_pde, accept, publish, drop;

    // Handshake: spike_valid has no back-pressure, so an event is either accepted in COLLECT
    // or dropped and counted. shift_en marks new codes; gs_ready (pulse or level) releases them.
    assign in_pde = (state == PDE);

    for (genvar g = 0; g < G_NUM; g++) begin : g_code
        assign code_d0[g] = |pend_0[g*GRP_W +: GRP_W];
        assign code_d1[g] = |pend_1[g*GRP_W +: GRP_W];
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        publish = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_pde) state_d = COLLECT;
            end
            COLLECT: begin
                if (in_pde) accept  = spike_valid;
                else        state_d = PUBLISH;
            end
            PUBLISH: begin
                if (consumed) begin
                    publish = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign drop = spike_valid & ~accept;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            consumed    <= 1'b1;
            pend_0      <= '0;
            pend_1      <= '0;
            GS_code_0   <= '0;
            GS_code_1   <= '0;
            spike_map_0 <= '0;
            spike_map_1 <= '0;
            shift_en    <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state_q  <= state_d;
            shift_en <= publish;
            if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
            if (publish) begin
                GS_code_0   <= code_d0;
                GS_code_1   <= code_d1;
                spike_map_0 <= pend_0;
                spike_map_1 <= pend_1;
                pend_0      <= '0;
                pend_1      <= '0;
                // Empty codes are never acknowledged, so they must not block the next round.
                consumed    <= (code_d0 == '0) && (code_d1 == '0);
            end else begin
                if (accept && !spike_src) pend_0[spike_idx] <= 1'b1;
                if (accept &&  spike_src) pend_1[spike_idx] <= 1'b1;
                if (gs_ready) consumed <= 1'b1;
            end
        end
    end

`ifdef SPIKE_CNT_EN
    function automatic logic [N_SZ:0] popcount(input logic [N_NUM-1:0] m);
        logic [N_SZ:0] sum;
        sum = '0;
        for (int i = 0; i < N_NUM; i++) sum = sum + {{N_SZ{1'b0}}, m[i]};
        return sum;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            spike_cnt_0 <= '0;
            spike_cnt_1 <= '0;
        end else if (publish) begin
            spike_cnt_0 <= popcount(pend_0);
            spike_cnt_1 <= popcount(pend_1);
        end
    end
`else
    assign spike_cnt_0 = '0;
    assign spike_cnt_1 = '0;
`endif

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_group_spike_encoder.sv
// Bench for group_spike_encoder: scenario tasks with inline checks plus a publish scoreboard.
module tb_group_spike_encoder;
  localparam logic [2:0] PDE = 3'b100;
  localparam logic [2:0] FIN = 3'b101;
  localparam int REC_W = 84;
`ifdef SPIKE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] phase = FIN;
  logic spike_valid = 1'b0;
  logic spike_src = 1'b0;
  logic [4:0] spike_idx = '0;
  logic gs_ready = 1'b0;
  logic [3:0] GS_code_0, GS_code_1;
  logic [31:0] spike_map_0, spike_map_1;
  logic shift_en, busy;
  logic [7:0] drop_cnt;
  logic [5:0] spike_cnt_0, spike_cnt_1;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;
  int exp_drop = 0;
  logic [31:0] m_pend0 = '0;
  logic [31:0] m_pend1 = '0;
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] held = '0;
  logic [REC_W-1:0] got_rec;
  logic [REC_W-1:0] exp_rec;
  bit mon_en = 1'b0;
  bit prev_shift = 1'b0;

  group_spike_encoder dut (
    .clk(clk), .rst(rst), .state(phase), .spike_valid(spike_valid), .spike_src(spike_src),
    .spike_idx(spike_idx), .gs_ready(gs_ready), .GS_code_0(GS_code_0), .GS_code_1(GS_code_1),
    .spike_map_0(spike_map_0), .spike_map_1(spike_map_1), .shift_en(shift_en), .busy(busy),
    .drop_cnt(drop_cnt), .spike_cnt_0(spike_cnt_0), .spike_cnt_1(spike_cnt_1),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign got_rec = {GS_code_1, GS_code_0, spike_map_1, spike_map_0, spike_cnt_1, spike_cnt_0};

  function automatic logic [REC_W-1:0] make_rec(input logic [31:0] m0, input logic [31:0] m1);
    logic [3:0] c0, c1;
    logic [5:0] n0, n1;
    for (int g = 0; g < 4; g++) begin
      c0[g] = |m0[g*8 +: 8];
      c1[g] = |m1[g*8 +: 8];
    end
    n0 = CNT_ON ? 6'($countones(m0)) : 6'd0;
    n1 = CNT_ON ? 6'($countones(m1)) : 6'd0;
    return {c1, c0, m1, m0, n1, n0};
  endfunction

  // scoreboard: pops on each publish, otherwise published data must hold
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (shift_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_publish got=%h", got_rec);
        end else begin
          exp_rec = exp_q.pop_front();
          if (got_rec !== exp_rec) begin
            bad++;
            $display("FAIL publish_data got=%h exp=%h", got_rec, exp_rec);
          end
        end
        held = got_rec;
      end else if (got_rec !== held) begin
        bad++;
        $display("FAIL output_hold got=%h exp=%h", got_rec, held);
      end
      total++;
      if (shift_en === 1'b1 && prev_shift) begin
        bad++;
        $display("FAIL shift_double got=1 exp=0");
      end
      prev_shift = (shift_en === 1'b1);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round();
    phase = PDE;
    tick();
    total++;
    if (dbg_state !== 2'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL enter_collect got=%0d/%b exp=1/1", dbg_state, busy);
    end
  endtask

  task automatic send(input bit src, input int idx, input bit acc);
    spike_valid = 1'b1;
    spike_src = src;
    spike_idx = 5'(idx);
    if (acc) begin
      if (src) m_pend1[idx] = 1'b1;
      else m_pend0[idx] = 1'b1;
    end else if (exp_drop < 255) exp_drop++;
    tick();
    spike_valid = 1'b0;
  endtask

  task automatic end_round(input bit ev, input bit src, input int idx);
    phase = FIN;
    if (ev) begin
      spike_valid = 1'b1;
      spike_src = src;
      spike_idx = 5'(idx);
      if (exp_drop < 255) exp_drop++;
    end
    exp_q.push_back(make_rec(m_pend0, m_pend1));
    m_pend0 = '0;
    m_pend1 = '0;
    tick();
    spike_valid = 1'b0;
    total++;
    if (dbg_state !== 2'd2 || shift_en !== 1'b0) begin
      bad++;
      $display("FAIL enter_publish got=%0d/%b exp=2/0", dbg_state, shift_en);
    end
  endtask

  task automatic wait_shift(input int budget, output int n);
    n = 0;
    while (shift_en !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic ack();
    gs_ready = 1'b1;
    tick();
    gs_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    total++;
    if (got_rec !== '0 || {shift_en, busy, drop_cnt, dbg_state} !== 12'd0) begin
      bad++;
      $display("FAIL reset_values got=%h/%b%b/%0d/%0d exp=0", got_rec, shift_en, busy, drop_cnt, dbg_state);
    end
    rst = 1'b1;
    held = '0;
    prev_shift = 1'b0;
    mon_en = 1'b1;
    tick();
    total++;
    if (dbg_state !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got=%0d/%b exp=0/0", dbg_state, busy);
    end
  endtask

  task automatic test_basic();
    int n;
    start_round();
    send(0, 3, 1);
    send(1, 31, 1);
    end_round(0, 0, 0);
    wait_shift(10, n);
    total++;
    if (n !== 1) begin
      bad++;
      $display("FAIL basic_latency got=%0d exp=1", n);
    end
    total++;
    if (GS_code_0 !== 4'b0001 || GS_code_1 !== 4'b1000) begin
      bad++;
      $display("FAIL basic_codes got=%b/%b exp=0001/1000", GS_code_0, GS_code_1);
    end
    total++;
    if (spike_map_0 !== 32'h0000_0008 || spike_map_1 !== 32'h8000_0000) begin
      bad++;
      $display("FAIL basic_maps got=%h/%h exp=00000008/80000000", spike_map_0, spike_map_1);
    end
    tick();
    total++;
    if (shift_en !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL basic_return_idle got=%b/%0d exp=0/0", shift_en, dbg_state);
    end
    ack();
  endtask

  task automatic test_duplicate();
    int n;
    start_round();
    for (int i = 0; i < 3; i++) send(0, 8, 1);
    end_round(0, 0, 0);
    wait_shift(10, n);
    total++;
    if (n !== 1 || GS_code_0 !== 4'b0010 || GS_code_1 !== 4'b0000) begin
      bad++;
      $display("FAIL dup_codes got=%0d/%b/%b exp=1/0010/0000", n, GS_code_0, GS_code_1);
    end
    total++;
    if (spike_cnt_0 !== (CNT_ON ? 6'd1 : 6'd0)) begin
      bad++;
      $display("FAIL dup_count got=%0d exp=%0d", spike_cnt_0, CNT_ON ? 1 : 0);
    end
  endtask

  task automatic test_stall();
    int n;
    start_round();
    send(1, 17, 1);
    send(0, 0, 1);
    end_round(0, 0, 0);
    wait_shift(4, n);
    total++;
    if (n !== 4 || dbg_state !== 2'd2) begin
      bad++;
      $display("FAIL stall_hold got=%0d/%0d exp=4/2", n, dbg_state);
    end
    phase = PDE;
    send(0, 5, 0);
    tick();
    phase = FIN;
    total++;
    if (drop_cnt !== 8'(exp_drop) || dbg_state !== 2'd2) begin
      bad++;
      $display("FAIL stall_drop got=%0d/%0d exp=%0d/2", drop_cnt, dbg_state, exp_drop);
    end
    gs_ready = 1'b1;
    tick();
    gs_ready = 1'b0;
    total++;
    if (shift_en !== 1'b0) begin
      bad++;
      $display("FAIL stall_early got=1 exp=0");
    end
    wait_shift(10, n);
    total++;
    if (n !== 1 || GS_code_0 !== 4'b0001 || GS_code_1 !== 4'b0100) begin
      bad++;
      $display("FAIL stall_release got=%0d/%b/%b exp=1/0001/0100", n, GS_code_0, GS_code_1);
    end
  endtask

  task automatic test_empty_and_coincide();
    int n;
    ack();
    start_round();
    end_round(0, 0, 0);
    wait_shift(10, n);
    total++;
    if (n !== 1 || GS_code_0 !== 4'b0000 || GS_code_1 !== 4'b0000) begin
      bad++;
      $display("FAIL empty_publish got=%0d/%b/%b exp=1/0000/0000", n, GS_code_0, GS_code_1);
    end
    start_round();
    send(0, 31, 1);
    send(1, 8, 1);
    end_round(0, 0, 0);
    gs_ready = 1'b1;
    wait_shift(10, n);
    gs_ready = 1'b0;
    total++;
    if (n !== 1 || GS_code_0 !== 4'b1000 || GS_code_1 !== 4'b0010) begin
      bad++;
      $display("FAIL after_empty got=%0d/%b/%b exp=1/1000/0010", n, GS_code_0, GS_code_1);
    end
    start_round();
    send(0, 1, 1);
    end_round(0, 0, 0);
    wait_shift(3, n);
    total++;
    if (n !== 3 || shift_en !== 1'b0) begin
      bad++;
      $display("FAIL coincide_stall got=%0d/%b exp=3/0", n, shift_en);
    end
    ack();
    wait_shift(10, n);
    total++;
    if (n !== 1 || GS_code_0 !== 4'b0001) begin
      bad++;
      $display("FAIL coincide_release got=%0d/%b exp=1/0001", n, GS_code_0);
    end
    ack();
  endtask

  task automatic test_drops();
    int n;
    start_round();
    send(0, 2, 1);
    end_round(1, 1, 9);
    wait_shift(10, n);
    total++;
    if (n !== 1 || GS_code_1 !== 4'b0000 || drop_cnt !== 8'(exp_drop)) begin
      bad++;
      $display("FAIL finish_drop got=%0d/%b/%0d exp=1/0000/%0d", n, GS_code_1, drop_cnt, exp_drop);
    end
    ack();
    for (int i = 0; i < 300; i++) send(1'($urandom_range(0, 1)), $urandom_range(0, 31), 0);
    total++;
    if (drop_cnt !== 8'd255) begin
      bad++;
      $display("FAIL drop_saturate got=%0d exp=255", drop_cnt);
    end
    start_round();
    end_round(0, 0, 0);
    wait_shift(10, n);
    total++;
    if (n !== 1 || spike_map_0 !== 32'd0 || spike_map_1 !== 32'd0) begin
      bad++;
      $display("FAIL idle_no_pending got=%0d/%h/%h exp=1/0/0", n, spike_map_0, spike_map_1);
    end
  endtask

  task automatic test_reset_stall();
    int n;
    start_round();
    send(0, 12, 1);
    end_round(0, 0, 0);
    wait_shift(10, n);
    start_round();
    send(1, 4, 1);
    end_round(0, 0, 0);
    tick();
    total++;
    if (dbg_state !== 2'd2 || shift_en !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset_stall got=%0d/%b exp=2/0", dbg_state, shift_en);
    end
    mon_en = 1'b0;
    rst = 1'b0;
    tick();
    total++;
    if (got_rec !== '0 || {shift_en, busy, drop_cnt, dbg_state} !== 12'd0) begin
      bad++;
      $display("FAIL mid_reset got=%h/%b%b/%0d/%0d exp=0", got_rec, shift_en, busy, drop_cnt, dbg_state);
    end
    rst = 1'b1;
    exp_q.delete();
    m_pend0 = '0;
    m_pend1 = '0;
    exp_drop = 0;
    held = '0;
    prev_shift = 1'b0;
    mon_en = 1'b1;
    start_round();
    send(0, 30, 1);
    end_round(0, 0, 0);
    wait_shift(10, n);
    total++;
    if (n !== 1 || GS_code_0 !== 4'b1000 || GS_code_1 !== 4'b0000) begin
      bad++;
      $display("FAIL post_reset_round got=%0d/%b/%b exp=1/1000/0000", n, GS_code_0, GS_code_1);
    end
  endtask

  // report
  initial begin
    test_reset();
    test_basic();
    test_duplicate();
    test_stall();
    test_empty_and_coincide();
    test_drops();
    test_reset_stall();
    tick();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drained got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/group_spike_encoder.md
# group_spike_encoder

Transmit-side counterpart of the group arrangement stage: collects per-neuron spike events produced during the PDE phase for two sources, compresses them into per-group spike codes (one bit per group of `N_NUM/G_NUM` neurons), and publishes `GS_code_0`/`GS_code_1` with a one-cycle `shift_en` pulse. The block double-buffers: a pending map is built while the previously published codes stay stable for the consumer. Publication waits for the consumer's completion acknowledge.

## Interface
- `N_NUM`, 32, neurons per source
- `G_NUM`, 4, groups per source; group g covers neuron indices [g*N_NUM/G_NUM, (g+1)*N_NUM/G_NUM-1]
- `N_SZ`, 5, log2(N_NUM)
- `G_SZ`, 2, log2(G_NUM)

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `state`  in  3  global phase; PDE = 3'b100, FINISH = 3'b101
- `spike_valid`  in  1  one spike event this cycle
- `spike_src`  in  1  source of event (0 or 1)
- `spike_idx`  in  N_SZ  neuron index of event
- `gs_ready`  in  1  consumer done with current codes (pulse or level)
- `GS_code_0`  out  G_NUM  published group codes, source 0
- `GS_code_1`  out  G_NUM  published group codes, source 1
- `spike_map_0`  out  N_NUM  published neuron spike map, source 0
- `spike_map_1`  out  N_NUM  published neuron spike map, source 1
- `shift_en`  out  1  one-cycle pulse: new codes valid
- `busy`  out  1  FSM not in IDLE
- `drop_cnt`  out  8  saturating count of discarded events
- `spike_cnt_0`, `spike_cnt_1`  out  N_SZ+1  distinct spikes in published map (see Configuration)

## Operation
- FSM states: IDLE, COLLECT, PUBLISH.
- IDLE -> COLLECT when `state`==PDE.
- COLLECT: event accepted only when `spike_valid` and `state`==PDE; sets `pend_map[spike_src][spike_idx]`. Duplicate indices are idempotent.
- COLLECT -> PUBLISH on first cycle with `state`!=PDE. An event presented in that cycle is dropped.
- Events arriving in IDLE or PUBLISH are dropped; `drop_cnt` increments, saturating at 255.
- Group code bit g = OR of the pending map bits in group g, computed from `pend_map` at publish.
- `consumed` flag: reset value 1; set by `gs_ready`==1; cleared by a publish with a nonzero code. An all-zero publish leaves it set, because the consumer never acknowledges empty codes.
- PUBLISH with `consumed`==1:
  - Next edge: outputs <= pending; `shift_en`<=1; `pend_map` cleared; FSM -> IDLE.
  - If `gs_ready` and the publish coincide, the publish wins when the code is nonzero, so `consumed` ends at 0.
- PUBLISH with `consumed`==0: stall; outputs and pending held.
- Published outputs change only at a publish edge; otherwise stable.
- All-zero rounds are still published, with `shift_en` pulsing and codes of 0.

## Timing
- Reset values:
  - FSM IDLE, `consumed`=1, `pend_map`=0.
  - All outputs 0, including `shift_en`, `busy`, `drop_cnt` and the counts.
- Accepted event at edge t: pending bit visible t+1.
- `state` leaves PDE at cycle t: FSM in PUBLISH at t+1.
- `consumed`==1 at t+1: `shift_en` high during t+2 only, with codes valid from t+2.
- `shift_en` is never high two consecutive cycles.
- Reset mid-operation discards pending and published data and returns to reset values on the next edge.
- `state` re-entering PDE while in PUBLISH does not start a new COLLECT until IDLE is reached; events in that window are dropped.

## Configuration
- `SPIKE_CNT_EN` defined:
  - `spike_cnt_0`/`spike_cnt_1` = popcount of the corresponding published map, registered with the publish edge.
  - Range 0..N_NUM, reset 0.
- `SPIKE_CNT_EN` undefined: the count ports are tied to 0 and no popcount logic is built.

## Test plan
- Reset, PDE, spikes src0 idx 3 and src1 idx 31, then FINISH -> `shift_en` pulses at t+2; `GS_code_0`=4'b0001, `GS_code_1`=4'b1000; maps carry bits 3 and 31.
- Round with src0 idx 8 sent three times -> `GS_code_0`=4'b0010, `spike_cnt_0`=1 with `SPIKE_CNT_EN`, 0 without.
- Nonzero round published, no `gs_ready`, second PDE round ends -> FSM stalls in PUBLISH and outputs are unchanged; `gs_ready` pulse -> `shift_en` two cycles later with the new codes.
- Empty PDE round -> `shift_en` pulse, codes 0, `consumed` stays 1; the next nonzero round publishes with no `gs_ready` needed.
- 300 `spike_valid` events during IDLE -> `drop_cnt`=255, no pending bits set; event in the FINISH cycle also dropped.
- `rst`=0 asserted while in PUBLISH stall -> next cycle all outputs 0, FSM IDLE, `consumed`=1.
